vc_flit_queue: RTL and testbench

//   Multi-virtual-channel flit FIFO. Holds NUM_VC independent FIFOs of DEPTH flits each, with valid/ready push and pop ports.
//   The push port is steered by a VC index. The pop port is selected by a VC index supplied by the downstream arbiter.

---
 rtl/vc_flit_queue_if.sv | 35 +++
 rtl/vc_flit_queue.sv | 122 ++++++++++++
 tb/tb_vc_flit_queue.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_flit_queue_if.sv
// Push/pop handshake and per-VC status bundle for the multi-VC flit queue.
// The slave side is the queue itself; the master side is the router/arbiter.
interface vc_flit_queue_if #(
  parameter int FLIT_WIDTH = 64,
  parameter int NUM_VC     = 4,
  parameter int DEPTH      = 4
);
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [FLIT_WIDTH-1:0]   pushed_flit;
  logic [VC_W-1:0]         pushed_vc;
  logic                    pushed_flit_valid;
  logic                    pushed_flit_ready;
  logic [VC_W-1:0]         poped_vc;
  logic                    poped_flit_ready;
  logic                    poped_flit_valid;
  logic [FLIT_WIDTH-1:0]   poped_flit;
  logic [NUM_VC*CNT_W-1:0] vc_count;
  logic [NUM_VC-1:0]       vc_empty;
  logic [NUM_VC-1:0]       vc_full;
  logic [NUM_VC-1:0]       vc_almost_full;

  modport master (
    output pushed_flit, pushed_vc, pushed_flit_valid, poped_vc, poped_flit_ready,
    input  pushed_flit_ready, poped_flit_valid, poped_flit,
    input  vc_count, vc_empty, vc_full, vc_almost_full
  );

  modport slave (
    input  pushed_flit, pushed_vc, pushed_flit_valid, poped_vc, poped_flit_ready,
    output pushed_flit_ready, poped_flit_valid, poped_flit,
    output vc_count, vc_empty, vc_full, vc_almost_full
  );
endinterface

// File: rtl/vc_flit_queue.sv
// NUM_VC independent circular flit FIFOs sharing one push port and one pop port,
// each steered by a VC index; per-VC status comes straight from registered counts.
module vc_flit_queue #(
  parameter int FLIT_WIDTH = 64,
  parameter int NUM_VC     = 4,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = 3
) (
  input logic            clk,
  input logic            rst,
  vc_flit_queue_if.slave q
);
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [FLIT_WIDTH-1:0] mem_q [NUM_VC][DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0]      wr_ptr_d [NUM_VC];
  logic [PTR_W-1:0]      rd_ptr_q [NUM_VC];
  logic [PTR_W-1:0]      rd_ptr_d [NUM_VC];
  logic [CNT_W-1:0]      cnt_q    [NUM_VC];
  logic [CNT_W-1:0]      cnt_d    [NUM_VC];
  logic [NUM_VC-1:0]     push_hit;
  logic [NUM_VC-1:0]     pop_hit;
  logic                  push_ready;
  logic                  pop_valid;
  logic [FLIT_WIDTH-1:0] pop_data;
  logic                  push_fire;
  logic                  pop_fire;

  // An index that matches no VC leaves push not ready and pop not valid.
  always_comb begin
    push_ready = 1'b0;
    pop_valid  = 1'b0;
    pop_data   = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (q.pushed_vc == VC_W'(v))
        push_ready = !rst && (cnt_q[v] != CNT_W'(DEPTH));
      if (q.poped_vc == VC_W'(v)) begin
        pop_valid = (cnt_q[v] != '0);
        if (cnt_q[v] != '0)
          pop_data = mem_q[v][rd_ptr_q[v]];
      end
    end
  end

  assign push_fire = q.pushed_flit_valid && push_ready;
  assign pop_fire  = q.poped_flit_ready && pop_valid;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    push_hit = '0;
    pop_hit  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      push_hit[v] = push_fire && (q.pushed_vc == VC_W'(v));
      pop_hit[v]  = pop_fire && (q.poped_vc == VC_W'(v));
      if (push_hit[v])
        wr_ptr_d[v] = (wr_ptr_q[v] == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q[v] + PTR_W'(1);
      if (pop_hit[v])
        rd_ptr_d[v] = (rd_ptr_q[v] == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q[v] + PTR_W'(1);
      case ({push_hit[v], pop_hit[v]})
        2'b10:   cnt_d[v] = cnt_q[v] + CNT_W'(1);
        2'b01:   cnt_d[v] = cnt_q[v] - CNT_W'(1);
        default: cnt_d[v] = cnt_q[v];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately left unreset; counts alone define what is valid.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push_hit[v])
        mem_q[v][wr_ptr_q[v]] <= q.pushed_flit;
    end
  end

  always_comb begin
    q.vc_count       = '0;
    q.vc_empty       = '0;
    q.vc_full        = '0;
    q.vc_almost_full = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      q.vc_count[v*CNT_W +: CNT_W] = cnt_q[v];
      q.vc_empty[v]                = (cnt_q[v] == '0);
      q.vc_full[v]                 = (cnt_q[v] == CNT_W'(DEPTH));
      q.vc_almost_full[v]          = (cnt_q[v] >= CNT_W'(AF_LEVEL));
    end
  end

  assign q.pushed_flit_ready = push_ready;
  assign q.poped_flit_valid  = pop_valid;
  assign q.poped_flit        = pop_data;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_chk
    a_cnt_max: assert property (@(posedge clk) disable iff (rst)
      cnt_q[g] <= CNT_W'(DEPTH));
    a_cnt_ptr: assert property (@(posedge clk) disable iff (rst)
      (cnt_q[g] == CNT_W'((int'(wr_ptr_q[g]) - int'(rd_ptr_q[g]) + DEPTH) % DEPTH)) ||
      ((cnt_q[g] == CNT_W'(DEPTH)) && (wr_ptr_q[g] == rd_ptr_q[g])));
    a_no_ovf: assert property (@(posedge clk) disable iff (rst)
      !(push_hit[g] && (cnt_q[g] == CNT_W'(DEPTH))));
    a_no_unf: assert property (@(posedge clk) disable iff (rst)
      !(pop_hit[g] && (cnt_q[g] == '0)));
  end
endmodule

// File: tb/tb_vc_flit_queue.sv
// Directed bench for vc_flit_queue: ordering, full/almost-full, simultaneous
// push/pop, pointer wrap, VC isolation and asynchronous reset.
module tb_vc_flit_queue;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vc_flit_queue_if #(.FLIT_WIDTH(64), .NUM_VC(4), .DEPTH(4)) bus ();

  vc_flit_queue #(.FLIT_WIDTH(64), .NUM_VC(4), .DEPTH(4), .AF_LEVEL(3)) dut (
    .clk(clk),
    .rst(rst),
    .q  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] cnt_of(input int v);
    return bus.vc_count[v*3 +: 3];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] vc, input logic [63:0] d);
    bus.pushed_vc         = vc;
    bus.pushed_flit       = d;
    bus.pushed_flit_valid = 1'b1;
    step();
    bus.pushed_flit_valid = 1'b0;
  endtask

  task automatic pop(input logic [1:0] vc);
    bus.poped_vc         = vc;
    bus.poped_flit_ready = 1'b1;
    step();
    bus.poped_flit_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.vc_empty !== 4'hF || bus.vc_full !== 4'h0 || bus.vc_almost_full !== 4'h0) begin
      errors++;
      $display("FAIL reset_flags empty=%h full=%h af=%h want F/0/0", bus.vc_empty, bus.vc_full, bus.vc_almost_full);
    end
    checks++;
    if (bus.poped_flit_valid !== 1'b0 || bus.poped_flit !== 64'h0 || bus.pushed_flit_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ports pv=%b pf=%h pr=%b want 0/0/0", bus.poped_flit_valid, bus.poped_flit, bus.pushed_flit_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus.pushed_flit_ready !== 1'b1 || bus.vc_count !== 12'h0) begin
      errors++;
      $display("FAIL post_reset pr=%b cnt=%h want 1/000", bus.pushed_flit_ready, bus.vc_count);
    end
  endtask

  task automatic test_order();
    logic [63:0] exp [3];
    exp[0] = 64'hA; exp[1] = 64'hB; exp[2] = 64'hC;
    bus.poped_vc = 2'd1;
    push(2'd1, exp[0]);
    checks++;
    if (bus.poped_flit !== exp[0] || bus.poped_flit_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency flit=%h valid=%b want %h/1", bus.poped_flit, bus.poped_flit_valid, exp[0]);
    end
    push(2'd1, exp[1]);
    push(2'd1, exp[2]);
    checks++;
    if (cnt_of(1) !== 3'd3 || bus.poped_flit !== exp[0]) begin
      errors++;
      $display("FAIL order_fill cnt=%0d flit=%h want 3/%h", cnt_of(1), bus.poped_flit, exp[0]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.poped_flit !== exp[i] || bus.poped_flit_valid !== 1'b1) begin
        errors++;
        $display("FAIL order_pop%0d flit=%h valid=%b want %h/1", i, bus.poped_flit, bus.poped_flit_valid, exp[i]);
      end
      pop(2'd1);
    end
    checks++;
    if (bus.vc_empty[1] !== 1'b1 || bus.poped_flit_valid !== 1'b0 || bus.poped_flit !== 64'h0) begin
      errors++;
      $display("FAIL order_empty empty=%b valid=%b flit=%h want 1/0/0", bus.vc_empty[1], bus.poped_flit_valid, bus.poped_flit);
    end
    // ready on an empty VC must not underflow
    pop(2'd1);
    checks++;
    if (cnt_of(1) !== 3'd0) begin
      errors++;
      $display("FAIL underflow cnt=%0d want 0", cnt_of(1));
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      push(2'd0, 64'h100 + 64'(i));
      checks++;
      if (bus.vc_almost_full[0] !== (i >= 2) || bus.vc_full[0] !== (i == 3) || cnt_of(0) !== 3'(i + 1)) begin
        errors++;
        $display("FAIL fill%0d af=%b full=%b cnt=%0d want %b/%b/%0d", i, bus.vc_almost_full[0], bus.vc_full[0], cnt_of(0), i >= 2, i == 3, i + 1);
      end
    end
    bus.pushed_vc = 2'd0;
    #1;
    checks++;
    if (bus.pushed_flit_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_full got=%b want 0", bus.pushed_flit_ready);
    end
    bus.pushed_vc = 2'd2;
    #1;
    checks++;
    if (bus.pushed_flit_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_other got=%b want 1", bus.pushed_flit_ready);
    end
  endtask

  task automatic test_simultaneous();
    bus.pushed_vc         = 2'd0;
    bus.pushed_flit       = 64'hBAD;
    bus.pushed_flit_valid = 1'b1;
    bus.poped_vc          = 2'd0;
    bus.poped_flit_ready  = 1'b1;
    #1;
    checks++;
    if (bus.pushed_flit_ready !== 1'b0 || bus.poped_flit !== 64'h100) begin
      errors++;
      $display("FAIL simul_full_pre pr=%b flit=%h want 0/100", bus.pushed_flit_ready, bus.poped_flit);
    end
    step();
    bus.pushed_flit_valid = 1'b0;
    bus.poped_flit_ready  = 1'b0;
    #1;
    checks++;
    if (cnt_of(0) !== 3'd3 || bus.poped_flit !== 64'h101) begin
      errors++;
      $display("FAIL simul_full cnt=%0d flit=%h want 3/101", cnt_of(0), bus.poped_flit);
    end
    pop(2'd0);
    bus.pushed_vc         = 2'd0;
    bus.pushed_flit       = 64'h200;
    bus.pushed_flit_valid = 1'b1;
    bus.poped_flit_ready  = 1'b1;
    step();
    bus.pushed_flit_valid = 1'b0;
    bus.poped_flit_ready  = 1'b0;
    #1;
    checks++;
    if (cnt_of(0) !== 3'd2 || bus.poped_flit !== 64'h103) begin
      errors++;
      $display("FAIL simul_mid cnt=%0d flit=%h want 2/103", cnt_of(0), bus.poped_flit);
    end
    pop(2'd0);
    checks++;
    if (bus.poped_flit !== 64'h200 || cnt_of(0) !== 3'd1) begin
      errors++;
      $display("FAIL simul_tail flit=%h cnt=%0d want 200/1", bus.poped_flit, cnt_of(0));
    end
    pop(2'd0);
  endtask

  task automatic test_wrap();
    int bad;
    bad = 0;
    bus.poped_vc = 2'd3;
    push(2'd3, 64'd0);
    for (int i = 1; i < 10; i++) begin
      if (bus.poped_flit !== 64'(i - 1)) bad++;
      bus.pushed_vc         = 2'd3;
      bus.pushed_flit       = 64'(i);
      bus.pushed_flit_valid = 1'b1;
      bus.poped_flit_ready  = 1'b1;
      step();
      if (cnt_of(3) !== 3'd1) bad++;
    end
    bus.pushed_flit_valid = 1'b0;
    bus.poped_flit_ready  = 1'b0;
    #1;
    checks++;
    if (bad != 0 || bus.poped_flit !== 64'd9) begin
      errors++;
      $display("FAIL wrap bad=%0d last=%h want 0/9", bad, bus.poped_flit);
    end
    pop(2'd3);
    checks++;
    if (bus.vc_empty[3] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_empty got=%b want 1", bus.vc_empty[3]);
    end
  endtask

  task automatic test_interleave();
    push(2'd0, 64'hA0);
    push(2'd2, 64'hC0);
    push(2'd0, 64'hA1);
    push(2'd2, 64'hC1);
    bus.pushed_vc         = 2'd0;
    bus.pushed_flit       = 64'hA2;
    bus.pushed_flit_valid = 1'b1;
    bus.poped_vc          = 2'd2;
    bus.poped_flit_ready  = 1'b1;
    step();
    bus.pushed_flit_valid = 1'b0;
    bus.poped_flit_ready  = 1'b0;
    #1;
    checks++;
    if (cnt_of(0) !== 3'd3 || cnt_of(2) !== 3'd1 || bus.poped_flit !== 64'hC1) begin
      errors++;
      $display("FAIL interleave c0=%0d c2=%0d flit=%h want 3/1/C1", cnt_of(0), cnt_of(2), bus.poped_flit);
    end
    pop(2'd2);
    bus.poped_vc = 2'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.poped_flit !== 64'hA0 + 64'(i)) begin
        errors++;
        $display("FAIL vc0_order%0d flit=%h want %h", i, bus.poped_flit, 64'hA0 + 64'(i));
      end
      pop(2'd0);
    end
  endtask

  task automatic test_reset_mid();
    push(2'd0, 64'h11);
    push(2'd1, 64'h22);
    push(2'd3, 64'h33);
    bus.poped_vc = 2'd0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.vc_empty !== 4'hF || bus.poped_flit_valid !== 1'b0 || bus.vc_count !== 12'h0 || bus.pushed_flit_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_rst empty=%h pv=%b cnt=%h pr=%b want F/0/000/0", bus.vc_empty, bus.poped_flit_valid, bus.vc_count, bus.pushed_flit_ready);
    end
    step();
    rst = 1'b0;
    bus.poped_vc = 2'd2;
    push(2'd2, 64'h77);
    checks++;
    if (bus.poped_flit !== 64'h77 || cnt_of(2) !== 3'd1 || bus.vc_empty !== 4'hB) begin
      errors++;
      $display("FAIL after_rst flit=%h cnt=%0d empty=%h want 77/1/B", bus.poped_flit, cnt_of(2), bus.vc_empty);
    end
  endtask

  initial begin
    checks                = 0;
    errors                = 0;
    rst                   = 1'b1;
    bus.pushed_flit       = '0;
    bus.pushed_vc         = '0;
    bus.pushed_flit_valid = 1'b0;
    bus.poped_vc          = '0;
    bus.poped_flit_ready  = 1'b0;
    test_reset();
    test_order();
    test_full();
    test_simultaneous();
    test_wrap();
    test_interleave();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
